// File: rtl/alu_pkg.sv
// Purpose: shared op codes, buffer state encoding and result entry layout for the ALU result stage.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_CMP = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_e;

  // One buffered result: value, op code it came from, and {eq,gt,lt}.
  typedef struct packed {
    logic [4:0] result;
    logic [1:0] sel;
    logic [2:0] flags;
  } entry_t;

  // Bit 4 is only a carry/borrow for add and sub; for and/compare it is not meaningful.
  function automatic logic carry_of(input logic [1:0] sel, input logic [4:0] result);
    return ((op_e'(sel) == OP_ADD) || (op_e'(sel) == OP_SUB)) && result[4];
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Purpose: groups the producer-side (ALU) and consumer-side signals of the result stage.
// Latency: n/a (wiring only).
// Backpressure: in_ready toward the ALU, out_ready from the consumer.
// Ports: ALU side in_valid/in_ready/sel/y_add/y_sub/y_and/eq/gt/lt;
//        consumer side out_valid/out_ready/out_result/out_sel/out_flags/out_carry; evt_cnt.
interface alu_result_stage_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sel;
  logic [4:0] y_add;
  logic [4:0] y_sub;
  logic [3:0] y_and;
  logic       eq;
  logic       gt;
  logic       lt;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_result;
  logic [1:0] out_sel;
  logic [2:0] out_flags;
  logic       out_carry;
  logic [7:0] evt_cnt;

  // master: drives ALU results and consumer ready (e.g. a test harness)
  modport master (
    output in_valid, sel, y_add, y_sub, y_and, eq, gt, lt, out_ready,
    input  in_ready, out_valid, out_result, out_sel, out_flags, out_carry, evt_cnt
  );

  // slave: the result stage itself
  modport slave (
    input  in_valid, sel, y_add, y_sub, y_and, eq, gt, lt, out_ready,
    output in_ready, out_valid, out_result, out_sel, out_flags, out_carry, evt_cnt
  );
endinterface

// File: rtl/alu_result_sel.sv
// Purpose: combinational select of the ALU result by op code, plus the carry/borrow bit.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake.
// Ports: i_sel, i_y_add, i_y_sub, i_y_and, i_eq, i_gt, i_lt in; o_result[4:0], o_carry out.
module alu_result_sel
  import alu_pkg::*;
(
  input  logic [1:0] i_sel,
  input  logic [4:0] i_y_add,
  input  logic [4:0] i_y_sub,
  input  logic [3:0] i_y_and,
  input  logic       i_eq,
  input  logic       i_gt,
  input  logic       i_lt,
  output logic [4:0] o_result,
  output logic       o_carry
);

  logic [4:0] w_result;

  always_comb begin
    w_result = '0;
    case (op_e'(i_sel))
      OP_ADD:  w_result = i_y_add;
      OP_SUB:  w_result = i_y_sub;
      OP_AND:  w_result = {1'b0, i_y_and};
      OP_CMP:  w_result = {2'b00, i_eq, i_gt, i_lt};
      default: w_result = '0;
    endcase
  end

  assign o_result = w_result;
  assign o_carry  = carry_of(i_sel, w_result);

endmodule

// File: rtl/alu_result_stage.sv
// Purpose: 2-entry in-order buffer for ALU results with EMPTY/ONE/FULL control FSM.
// Latency: 1 cycle from push to out_* when empty.
// Backpressure: in_ready drops only in FULL (state-decoded, no path from out_ready).
// Ports: clk, rst (sync, active-high), bus (alu_result_stage_if.slave).
// Optional feature: define ALU_RESULT_EVT_CNT_EN for a saturating carry-event counter on evt_cnt.
module alu_result_stage
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  alu_result_stage_if.slave    bus
);

  state_e     r_state;
  state_e     w_state_nxt;
  entry_t     r_head;
  entry_t     r_tail;
  entry_t     w_new;
  logic [4:0] w_result;
  logic       w_carry;
  logic       w_in_ready;
  logic       w_out_valid;
  logic       w_push;
  logic       w_pop;
  logic       w_head_new;
  logic       w_head_tail;
  logic       w_tail_new;

  alu_result_sel u_sel (
    .i_sel    (bus.sel),
    .i_y_add  (bus.y_add),
    .i_y_sub  (bus.y_sub),
    .i_y_and  (bus.y_and),
    .i_eq     (bus.eq),
    .i_gt     (bus.gt),
    .i_lt     (bus.lt),
    .o_result (w_result),
    .o_carry  (w_carry)
  );

  assign w_new = '{result: w_result, sel: bus.sel, flags: {bus.eq, bus.gt, bus.lt}};

  // Gating with rst keeps the handshake closed for the whole reset cycle, so any
  // push or pop attempted while rst is high never takes effect.
  assign w_in_ready  = !rst && (r_state != FULL);
  assign w_out_valid = !rst && (r_state != EMPTY);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_head_new  = 1'b0;
    w_head_tail = 1'b0;
    w_tail_new  = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_push) begin
          w_state_nxt = ONE;
          w_head_new  = 1'b1;
        end
      end
      ONE: begin
        if (w_push && w_pop) begin
          // old head leaves and the new entry replaces it in place
          w_head_new = 1'b1;
        end else if (w_push) begin
          w_state_nxt = FULL;
          w_tail_new  = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_pop) begin
          w_state_nxt = ONE;
          w_head_tail = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_head_new) begin
        r_head <= w_new;
      end else if (w_head_tail) begin
        r_head <= r_tail;
      end
      if (w_tail_new) begin
        r_tail <= w_new;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_result = rst ? 5'd0 : r_head.result;
  assign bus.out_sel    = rst ? 2'd0 : r_head.sel;
  assign bus.out_flags  = rst ? 3'd0 : r_head.flags;
  assign bus.out_carry  = !rst && carry_of(r_head.sel, r_head.result);

`ifdef ALU_RESULT_EVT_CNT_EN
  logic [7:0] r_evt_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt_cnt <= '0;
    end else if (w_push && w_carry && (r_evt_cnt != 8'hFF)) begin
      r_evt_cnt <= r_evt_cnt + 8'd1;
    end
  end

  assign bus.evt_cnt = rst ? 8'd0 : r_evt_cnt;
`else
  logic w_unused_carry;
  assign w_unused_carry = w_carry;
  assign bus.evt_cnt    = 8'd0;
`endif

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameters: none; all widths are fixed at the 4-bit ALU datapath.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  ALU outputs and sel are valid this cycle.
REQ-005 in_ready  output  1  stage can accept a result this cycle.
REQ-006 sel  input  2  ALU op select: 00 add, 01 sub, 10 and, 11 compare.
REQ-007 y_add  input  5  ALU sum, including carry-out.
REQ-008 y_sub  input  5  ALU difference, including borrow bit.
REQ-009 y_and  input  4  ALU bitwise AND.
REQ-010 eq, gt, lt  input  1 each  ALU compare flags.
REQ-011 out_valid  output  1  out_* hold a buffered result.
REQ-012 out_ready  input  1  consumer accepts the result this cycle.
REQ-013 out_result  output  5  selected result.
REQ-014 out_sel  output  2  op code carried with the result.
REQ-015 out_flags  output  3  {eq,gt,lt} captured with the result.
REQ-016 out_carry  output  1  equals out_result[4] for add/sub; 0 otherwise.
REQ-017 evt_cnt  output  8  carry-event count (see Configuration).

Function
REQ-018 Push = in_valid && in_ready; pop = out_valid && out_ready.
REQ-019 Selection at push: 00 -> y_add; 01 -> y_sub; 10 -> {1'b0,y_and}; 11 -> {2'b00,eq,gt,lt}.
REQ-020 Flags are captured at every push regardless of sel.
REQ-021 Storage is a 2-entry in-order buffer; FSM states are EMPTY, ONE and FULL.
REQ-022 EMPTY: push -> ONE; no push -> EMPTY.
REQ-023 ONE: push only -> FULL; pop only -> EMPTY; push and pop -> ONE, with the new entry at the head.
REQ-024 FULL: pop -> ONE; in_ready=0, so no push is possible.
REQ-025 in_ready = (state != FULL); it is a registered or state-decoded signal with no combinational path from out_ready.
REQ-026 out_valid = (state != EMPTY); out_* present the head entry and do not change while out_valid && !out_ready.
REQ-027 Latency: a push in cycle N makes the result visible on out_* in cycle N+1 when the buffer was empty.
REQ-028 in_valid while in_ready=0: the input is ignored and no state changes.
REQ-029 Ordering: results pop in the same order they were pushed; there is no drop and no duplication.

Reset
REQ-030 While rst=1: state=EMPTY; out_valid=0; in_ready=0; out_result=0; out_sel=0; out_flags=0; out_carry=0; evt_cnt=0.
REQ-031 The cycle after rst deasserts, in_ready=1.
REQ-032 Reset asserted mid-operation flushes all buffered entries; any push or pop in that cycle is discarded.

Configuration
REQ-033 Macro ALU_RESULT_EVT_CNT_EN is defined: evt_cnt increments by 1 on each push with sel in {00,01} and selected bit 4 = 1, and saturates at 255.
REQ-034 Macro ALU_RESULT_EVT_CNT_EN is undefined: evt_cnt is constant 0, no counter logic exists, and the port is retained.

Structure
REQ-035 A shared package alu_pkg holds:
- the op encodings: OP_ADD, OP_SUB, OP_AND, OP_CMP;
- the state encoding EMPTY/ONE/FULL;
- the result entry layout: result[4:0], sel[1:0], flags[2:0].
REQ-036 One sub-module, alu_result_sel, is the combinational sel-to-result and carry mux; the buffer and FSM live in alu_result_stage.

Verification
REQ-037 Reset: hold rst=1 for 2 cycles -> all outputs 0; in_ready=1 the cycle after release.
REQ-038 Single op: push sel=00, y_add=11110 with out_ready=1 -> next cycle out_valid=1, out_result=11110, out_carry=1.
REQ-039 Backpressure: out_ready=0, push sel=01 (y_sub=00000, eq=1) then sel=10 (y_and=1111) -> in_ready=0 after 2 pushes; third in_valid is ignored; raising out_ready pops 00000 (flags=100), then 01111.
REQ-040 Simultaneous push/pop in ONE: push sel=11 with eq=1 while popping the prior entry -> state stays ONE; out_result=00100 next cycle.
REQ-041 Mid-operation reset: buffer FULL, assert rst for 1 cycle -> out_valid=0, evt_cnt=0, and no stale entry appears afterwards.
REQ-042 Counter with ALU_RESULT_EVT_CNT_EN: 300 pushes of sel=00, y_add=10000 -> evt_cnt=255; without the macro -> evt_cnt=0.
